mux_nx1_reg: RTL and testbench
==============================

// Module: mux_nx1_reg
// PURPOSE
//  Parametrised, registered N-to-1 channel selector with valid/ready handshake on both sides.
//  Selects one DATA_W-bit lane of a packed array, either by explicit select or by an internal
//  round-robin scan pointer, and holds the result until the downstream consumer accepts it.
//  Successor to the combinational 8x1 mux; sits between parallel sensor/data lanes and a serial consumer.
// PARAMETERS
//  N_CH    8                 number of input channels (>=2, need not be a power of 2)
//  DATA_W  1                 width of each channel
//  SEL_W   $clog2(N_CH)      select/pointer width (localparam, derived; not overridable)
// PORTS
//  clk_i        in   1             clock, all state on rising edge
//  rst_ni       in   1             asynchronous active-low reset
//  array_i      in   N_CH*DATA_W   packed lanes; lane k = array_i[k*DATA_W +: DATA_W]
//  sel_i        in   SEL_W         explicit channel select (DIRECT mode)
//  mode_i       in   1             0 = DIRECT, 1 = SCAN (mux_nx1_pkg::mode_e)
//  scan_clr_i   in   1             synchronous pulse: scan pointer -> 0
//  in_valid_i   in   1             upstream offers a sample
//  in_ready_o   out  1             block can accept a sample this cycle
//  out_o        out  DATA_W        registered selected lane
//  out_ch_o     out  SEL_W         channel index that produced out_o
//  out_err_o    out  1             1 = selected index >= N_CH (out_o forced 0)
//  out_valid_o  out  1             out_o/out_ch_o/out_err_o valid
//  out_ready_i  in   1             downstream accepts output
// BEHAVIOUR
//  - Reset (async assert, sync release): out_o=0, out_ch_o=0, out_err_o=0, out_valid_o=0, scan ptr=0, FSM=EMPTY.
//  - FSM states: EMPTY (out_valid_o=0), FULL (out_valid_o=1).
//    EMPTY --accept--> FULL; FULL --out_ready_i & !accept--> EMPTY; FULL --out_ready_i & accept--> FULL.
//  - in_ready_o = !out_valid_o | out_ready_i (combinational; no bubble on back-to-back transfers).
//  - accept = in_valid_i & in_ready_o. On accept, next cycle: out_o = lane[idx], out_ch_o = idx.
//    idx = sel_i in DIRECT, scan pointer in SCAN. Latency 1 cycle from accept to out_valid_o.
//  - Output registers change only on accept; held stable while out_valid_o & !out_ready_i.
//  - idx >= N_CH (non-power-of-2 N_CH only): out_o = 0, out_err_o = 1, transfer still completes.
//  - Scan pointer: increments on each accept in SCAN mode; wraps N_CH-1 -> 0. Unchanged in DIRECT.
//  - scan_clr_i has priority over increment: same-cycle clr + accept uses current ptr for the data,
//    then ptr -> 0.
//  - mode_i sampled only at accept; a mode change between transfers takes effect on the next
//    accept; scan ptr is NOT cleared by a mode change.
//  - Reset mid-transfer: held output dropped, out_valid_o=0 immediately (async).
// CONFIGURATION
//  - MUX_NX1_REG_SVA_EN defined: concurrent assertions compiled in:
//    (a) out_valid_o & !out_ready_i |=> outputs stable;
//    (b) accept |=> out_o == captured lane (or 0 when out_err_o);
//    (c) scan ptr < N_CH always.
//    Failures report via $error.
//  - Not defined: no assertion code; RTL function is identical.
// STRUCTURE
//  - mux_nx1_pkg:
//    - typedef enum logic {MODE_DIRECT, MODE_SCAN} mode_e;
//    - typedef enum logic {ST_EMPTY, ST_FULL} state_e;
//  - Sub-module mux_nx1_scan_ctr: parametrised by N_CH; ports clk_i, rst_ni, clr_i, inc_i, ptr_o.
//    Owns the wrap logic.
//  - Top: lane extraction, handshake FSM, output registers.
// TESTING
//  1. Reset/DIRECT sweep: N_CH=8, DATA_W=4, array_i=32'h76543210, sel_i=0..7, out_ready_i=1
//     -> out_o==sel_i one cycle after each accept, out_ch_o==sel_i.
//  2. Backpressure: FULL, out_ready_i=0 for 5 cycles, array_i changes -> in_ready_o=0,
//     outputs stable; release -> next sample accepted same cycle.
//  3. SCAN wrap: mode_i=1, in_valid_i=1 for 10 accepts -> out_ch_o sequence 0..7,0,1;
//     scan_clr_i on 4th accept -> following out_ch_o = 0.
//  4. Non-power-of-2: N_CH=5, sel_i=6, array_i all ones -> out_o=0, out_err_o=1, out_valid_o=1.
//  5. Reset mid-operation: assert rst_ni low while FULL and out_ready_i=0 -> out_valid_o=0
//     without a clock edge; scan ptr=0 after release.
//  6. Mode switch: DIRECT sel_i=3 accept, then SCAN with ptr=2 -> out_ch_o 3 then 2; run with
//     MUX_NX1_REG_SVA_EN defined, zero assertion failures.

Source files
------------

// File: rtl/mux_nx1_pkg.sv
// +----------------------------------------------------------------------+
// | Module   : mux_nx1_pkg                                               |
// | Brief    : Shared mode and handshake-state types for mux_nx1_reg.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

package mux_nx1_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/mux_nx1_scan_ctr.sv
// +----------------------------------------------------------------------+
// | Module   : mux_nx1_scan_ctr                                          |
// | Brief    : Round-robin scan pointer, wraps N_CH-1 -> 0; clear wins.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module mux_nx1_scan_ctr
    import mux_nx1_pkg::*;
#(
    parameter  int N_CH  = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [SEL_W-1:0] ptr_o
);

    localparam logic [SEL_W-1:0] c_last = SEL_W'(N_CH - 1);

    logic [SEL_W-1:0] r_ptr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else if (clr_i) begin
            r_ptr <= '0;
        end else if (inc_i) begin
            r_ptr <= (r_ptr == c_last) ? '0 : r_ptr + 1'b1;
        end
    end

    assign ptr_o = r_ptr;

endmodule

`default_nettype wire

// File: rtl/mux_nx1_reg.sv
// +----------------------------------------------------------------------+
// | Module   : mux_nx1_reg                                               |
// | Brief    : Registered N-to-1 lane selector with valid/ready on both  |
// |            sides; DIRECT or round-robin SCAN selection.              |
// |            Define MUX_NX1_REG_SVA_EN to compile in assertions.       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module mux_nx1_reg
    import mux_nx1_pkg::*;
#(
    parameter  int N_CH   = 8,
    parameter  int DATA_W = 1,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_CH*DATA_W-1:0] array_i,
    input  logic [SEL_W-1:0]       sel_i,
    input  logic                   mode_i,
    input  logic                   scan_clr_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    output logic [DATA_W-1:0]      out_o,
    output logic [SEL_W-1:0]       out_ch_o,
    output logic                   out_err_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i
);

    localparam logic [SEL_W:0] c_n_ch = (SEL_W + 1)'(N_CH);

    state_e             r_state;
    state_e             w_state_nxt;
    logic               w_accept;
    logic [SEL_W-1:0]   w_ptr;
    logic [SEL_W-1:0]   w_idx;
    logic               w_err;
    logic [DATA_W-1:0]  w_lane;
    logic [DATA_W-1:0]  r_out;
    logic [SEL_W-1:0]   r_ch;
    logic               r_err;

    assign out_valid_o = (r_state == ST_FULL);
    assign in_ready_o  = !out_valid_o || out_ready_i;
    assign w_accept    = in_valid_i && in_ready_o;
    assign w_idx       = (mode_e'(mode_i) == MODE_SCAN) ? w_ptr : sel_i;
    assign w_err       = ({1'b0, w_idx} >= c_n_ch);

    mux_nx1_scan_ctr #(
        .N_CH (N_CH)
    ) u_scan_ctr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (scan_clr_i),
        .inc_i  (w_accept && (mode_e'(mode_i) == MODE_SCAN)),
        .ptr_o  (w_ptr)
    );

    // Out-of-range indices match no lane, so the selected value falls to zero.
    always_comb begin
        w_lane = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_idx == SEL_W'(k)) begin
                w_lane = array_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
            ST_FULL:  if (out_ready_i && !w_accept) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_EMPTY;
            r_out   <= '0;
            r_ch    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_out <= w_lane;
                r_ch  <= w_idx;
                r_err <= w_err;
            end
        end
    end

    assign out_o    = r_out;
    assign out_ch_o = r_ch;
    assign out_err_o = r_err;

`ifdef MUX_NX1_REG_SVA_EN
    a_hold_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        out_valid_o && !out_ready_i |=>
            out_valid_o && $stable(out_o) && $stable(out_ch_o) && $stable(out_err_o))
        else $error("mux_nx1_reg: output changed while stalled");

    a_capture : assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_accept |=> (out_o == $past(w_lane)) && (!out_err_o || out_o == '0))
        else $error("mux_nx1_reg: captured lane mismatch");

    a_ptr_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
        {1'b0, w_ptr} < c_n_ch)
        else $error("mux_nx1_reg: scan pointer out of range");
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_nx1_reg.sv
// +----------------------------------------------------------------------+
// | Module   : tb_mux_nx1_reg                                            |
// | Brief    : Directed scoreboard bench for mux_nx1_reg (8x4 and 5x1).  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mux_nx1_reg;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [31:0] array;
    logic [2:0]  sel;
    logic        mode, scan_clr, in_valid, out_ready;
    logic        in_ready, out_valid, out_err;
    logic [3:0]  out_d;
    logic [2:0]  out_ch;

    logic [4:0]  array5;
    logic [2:0]  sel5;
    logic        mode5, scan_clr5, in_valid5, out_ready5;
    logic        in_ready5, out_valid5, out_err5;
    logic [0:0]  out5;
    logic [2:0]  out_ch5;

    typedef struct {
        logic [3:0] d;
        logic [2:0] ch;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   m_ptr;
    int   vectors;
    int   miscompares;

    mux_nx1_reg #(.N_CH(8), .DATA_W(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .array_i     (array),
        .sel_i       (sel),
        .mode_i      (mode),
        .scan_clr_i  (scan_clr),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_o       (out_d),
        .out_ch_o    (out_ch),
        .out_err_o   (out_err),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    mux_nx1_reg #(.N_CH(5), .DATA_W(1)) dut5 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .array_i     (array5),
        .sel_i       (sel5),
        .mode_i      (mode5),
        .scan_clr_i  (scan_clr5),
        .in_valid_i  (in_valid5),
        .in_ready_o  (in_ready5),
        .out_o       (out5),
        .out_ch_o    (out_ch5),
        .out_err_o   (out_err5),
        .out_valid_o (out_valid5),
        .out_ready_i (out_ready5)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        logic consume;
        logic accept;
        int   idx;
        exp_t e;
        #1;
        check("in_ready", 32'(in_ready), 32'(q.size() == 0 || out_ready));
        consume = (q.size() != 0) && out_ready;
        accept  = in_valid && (q.size() == 0 || out_ready);
        if (consume) void'(q.pop_front());
        if (accept) begin
            idx   = mode ? m_ptr : int'(sel);
            e.ch  = 3'(idx);
            e.err = 1'b0;
            e.d   = array[idx*4 +: 4];
            q.push_back(e);
        end
        if (scan_clr) m_ptr = 0;
        else if (accept && mode) m_ptr = (m_ptr + 1) % 8;
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("out_data", 32'(out_d), 32'(q[0].d));
            check("out_ch", 32'(out_ch), 32'(q[0].ch));
            check("out_err", 32'(out_err), 32'(q[0].err));
        end
        @(negedge clk);
    endtask

    initial begin
        int exp_seq[6];
        int exp5[6];
        exp_seq = '{2, 3, 4, 5, 0, 1};
        exp5    = '{0, 1, 2, 3, 4, 0};
        vectors = 0;
        miscompares = 0;
        m_ptr = 0;
        rst_n = 1'b0;
        array = 32'h76543210; sel = '0; mode = 1'b0; scan_clr = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        array5 = '0; sel5 = '0; mode5 = 1'b0; scan_clr5 = 1'b0;
        in_valid5 = 1'b0; out_ready5 = 1'b1;

        #3;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'(out_d), 32'd0);
        check("rst_ch", 32'(out_ch), 32'd0);
        check("rst_err", 32'(out_err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_valid5", 32'(out_valid5), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // DIRECT sweep
        in_valid = 1'b1;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            tick();
            check("sweep_out", 32'(out_d), 32'(s));
            check("sweep_ch", 32'(out_ch), 32'(s));
        end
        in_valid = 1'b0;
        tick();

        // Backpressure
        in_valid = 1'b1; sel = 3'd5; out_ready = 1'b0;
        tick();
        sel = 3'd2;
        for (int i = 0; i < 5; i++) begin
            array = $urandom;
            tick();
            check("bp_hold_out", 32'(out_d), 32'd5);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_ch", 32'(out_ch), 32'd2);
        array = 32'h76543210;

        // SCAN wrap, then clear on the 4th accept
        mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("scan_seq", 32'(out_ch), 32'(i % 8));
        end
        for (int i = 0; i < 6; i++) begin
            scan_clr = (i == 3);
            tick();
            check("scan_clr_seq", 32'(out_ch), 32'(exp_seq[i]));
        end
        scan_clr = 1'b0;

        // Async reset while stalled
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_out", 32'(out_d), 32'd0);
        q.delete();
        m_ptr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1; in_valid = 1'b1; mode = 1'b1;
        tick();
        check("rst_ptr_ch", 32'(out_ch), 32'd0);

        // Mode switch keeps the scan pointer
        tick();
        mode = 1'b0; sel = 3'd3;
        tick();
        check("mode_direct_ch", 32'(out_ch), 32'd3);
        mode = 1'b1;
        tick();
        check("mode_scan_ch", 32'(out_ch), 32'd2);
        in_valid = 1'b0;
        tick();

        // Non-power-of-2 channel count
        in_valid5 = 1'b1; sel5 = 3'd6; array5 = 5'b11111;
        @(posedge clk);
        #1;
        check("np2_out", 32'(out5), 32'd0);
        check("np2_err", 32'(out_err5), 32'd1);
        check("np2_valid", 32'(out_valid5), 32'd1);
        check("np2_ch", 32'(out_ch5), 32'd6);
        sel5 = 3'd4;
        @(posedge clk);
        #1;
        check("np2_last_out", 32'(out5), 32'd1);
        check("np2_last_err", 32'(out_err5), 32'd0);
        mode5 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("np2_scan_ch", 32'(out_ch5), 32'(exp5[i]));
        end
        in_valid5 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
